// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: loader FSM states and framing constants
package imem_boot_loader_pkg;
   typedef enum logic [2:0] {
      LDR_HDR_HI,
      LDR_HDR_LO,
      LDR_LOAD,
      LDR_CSUM,
      LDR_DONE,
      LDR_ERR
   } loader_state_e;
   localparam int LDR_BYTES_PER_WORD = 4;
   localparam int LDR_HDR_BYTES = 2;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: valid/ready byte stream into the loader
interface imem_boot_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// imem_boot_loader_word_assembler: packs bytes MSB-first into words and keeps a running XOR checksum
module imem_boot_loader_word_assembler
   import imem_boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        i_clear,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic        o_last,
   output logic [31:0] o_word,
   output logic        o_word_valid,
   output logic [7:0]  o_csum
);
   logic [31:0] r_word;
   logic [1:0]  r_idx;
   logic [7:0]  r_csum;
   logic        r_word_valid;
   assign o_last       = i_en & (r_idx == 2'(LDR_BYTES_PER_WORD - 1));
   assign o_word       = r_word;
   assign o_word_valid = r_word_valid;
   assign o_csum       = r_csum;
   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_word       <= '0;
         r_idx        <= '0;
         r_csum       <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= o_last;
         if (i_en) begin
            r_word <= {r_word[23:0], i_byte};
            r_idx  <= r_idx + 2'd1;
            r_csum <= r_csum ^ i_byte;
         end
      end
   end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed program image, writes it to instruction memory and releases core reset once verified
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 512,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH),
   parameter int LOAD_BASE  = 0
) (
   input  logic              clk,
   input  logic              rst,
   imem_boot_loader_if.slave rx,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_core_rst,
   output logic              o_load_done,
   output logic              o_load_err,
   output logic [ADDR_W:0]   o_words_loaded
);
   loader_state_e     r_state;
   logic [7:0]        r_hdr_hi;
   logic [15:0]       r_n;
   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_core_rst;
   logic              r_done;
   logic              r_err;
   logic              w_xfer;
   logic              w_last;
   logic              w_ok;
   logic              w_over;
   logic              w_final;
   logic [15:0]       w_n;
   logic [7:0]        w_csum;
   assign rx.rx_ready = (r_state inside {LDR_HDR_HI, LDR_HDR_LO, LDR_LOAD, LDR_CSUM}) & ~rst;
   assign w_xfer  = rx.rx_valid & rx.rx_ready;
   assign w_n     = {r_hdr_hi, rx.rx_data};
   assign w_over  = 32'(w_n) > 32'(IMEM_DEPTH - LOAD_BASE);
   assign w_final = 32'(r_cnt) + 32'd1 == 32'(r_n);
   assign w_ok    = rx.rx_data == w_csum;
   // Reset doubles as the assembler clear so a partial word can never be written.
   imem_boot_loader_word_assembler u_asm (
      .clk          (clk),
      .i_clear      (rst),
      .i_en         (w_xfer & (r_state == LDR_LOAD)),
      .i_byte       (rx.rx_data),
      .o_last       (w_last),
      .o_word       (o_imem_wdata),
      .o_word_valid (o_imem_we),
      .o_csum       (w_csum)
   );
   assign o_imem_addr    = r_addr;
   assign o_core_rst     = r_core_rst;
   assign o_load_done    = r_done;
   assign o_load_err     = r_err;
   assign o_words_loaded = r_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= LDR_HDR_HI;
         r_hdr_hi   <= '0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_addr     <= ADDR_W'(LOAD_BASE);
         r_core_rst <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            LDR_HDR_HI: if (w_xfer) begin
               r_hdr_hi <= rx.rx_data;
               r_state  <= LDR_HDR_LO;
            end
            LDR_HDR_LO: if (w_xfer) begin
               r_n     <= w_n;
               r_state <= (w_n == 16'd0) ? LDR_CSUM : w_over ? LDR_ERR : LDR_LOAD;
               r_err   <= w_over;
            end
            LDR_LOAD: if (w_last) begin
               r_cnt  <= r_cnt + 1'b1;
               r_addr <= ADDR_W'(LOAD_BASE) + r_cnt[ADDR_W-1:0];
               if (w_final) r_state <= LDR_CSUM;
            end
            LDR_CSUM: if (w_xfer) begin
               r_state    <= w_ok ? LDR_DONE : LDR_ERR;
               r_done     <= w_ok;
               r_core_rst <= ~w_ok;
               r_err      <= ~w_ok;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for the boot loader, expected writes queued as bytes are sent
module tb_imem_boot_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [8:0]  addr;
   logic [31:0] wdata;
   logic        core_rst;
   logic        done;
   logic        err;
   logic [9:0]  words;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [8:0]  last_addr = '0;
   typedef struct {
      logic [8:0]  a;
      logic [31:0] d;
      int          c;
   } wr_t;
   wr_t        q[$];
   logic [7:0] frm[$];
   imem_boot_loader_if bus ();
   imem_boot_loader dut (
      .clk            (clk),
      .rst            (rst),
      .rx             (bus.slave),
      .o_imem_we      (we),
      .o_imem_addr    (addr),
      .o_imem_wdata   (wdata),
      .o_core_rst     (core_rst),
      .o_load_done    (done),
      .o_load_err     (err),
      .o_words_loaded (words)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (q.size() == 0) chk("spurious_we", {55'd0, addr}, 64'h1ff_ffff);
         else begin
            wr_t e;
            e = q.pop_front();
            chk("wr_addr", addr, e.a);
            chk("wr_data", wdata, e.d);
            chk("wr_latency", cyc, e.c);
            last_addr = addr;
         end
      end
   end
   task automatic send(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      t = 0;
      while (!bus.rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t == 50) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
   endtask
   task automatic run(input int maxgap, input int nsend);
      int n;
      n = {frm[0], frm[1]};
      for (int i = 0; i < nsend; i++) begin
         send(frm[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
         if (n <= 512 && i >= 2 && i < 2 + 4 * n && (i - 2) % 4 == 3)
            q.push_back('{a: 9'((i - 2) / 4), d: {frm[i-3], frm[i-2], frm[i-1], frm[i]}, c: cyc});
      end
   endtask
   task automatic mk3(input logic corrupt);
      logic [31:0] w[3];
      logic [7:0]  cs;
      w = '{32'h20010001, 32'h200f000f, 32'h08100009};
      cs = 8'h00;
      frm = '{8'h00, 8'h03};
      for (int i = 0; i < 3; i++)
         for (int j = 3; j >= 0; j--) begin
            frm.push_back(w[i][8*j +: 8]);
            cs ^= w[i][8*j +: 8];
         end
      frm.push_back(corrupt ? cs ^ 8'h03 : cs);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      @(negedge clk);
      chk("rdy_in_rst", bus.rx_ready, 0);
      rst = 1'b0;
   endtask
   task automatic end_chk(input string tag, input logic e_done, input logic e_err, input int e_words);
      repeat (3) @(negedge clk);
      chk({tag, "_pending"}, q.size(), 0);
      chk({tag, "_done"}, done, e_done);
      chk({tag, "_err"}, err, e_err);
      chk({tag, "_core_rst"}, core_rst, !e_done);
      chk({tag, "_ready"}, bus.rx_ready, 0);
      chk({tag, "_words"}, words, e_words);
   endtask
   initial begin
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rdy_in_rst", bus.rx_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_addr", addr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_core_rst", core_rst, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_words", words, 0);
      chk("rst_ready", bus.rx_ready, 1);
      // contiguous 3-word load, checking core reset release timing around the checksum byte
      mk3(1'b0);
      chk("csum_byte", frm[14], 8'h11);
      run(0, frm.size() - 1);
      chk("pre_csum_core_rst", core_rst, 1);
      send(frm[14], 0);
      chk("post_csum_core_rst", core_rst, 0);
      chk("post_csum_done", done, 1);
      end_chk("t1", 1, 0, 3);
      @(negedge clk);
      bus.rx_data = 8'hA5;
      bus.rx_valid = 1'b1;
      repeat (4) @(negedge clk);
      bus.rx_valid = 1'b0;
      end_chk("t1_ignore", 1, 0, 3);
      do_reset();
      mk3(1'b0);
      run(5, frm.size());
      end_chk("t2_gaps", 1, 0, 3);
      do_reset();
      mk3(1'b1);
      run(0, frm.size());
      end_chk("t3_badcs", 0, 1, 3);
      do_reset();
      frm = '{8'h00, 8'h00, 8'h00};
      run(0, 3);
      end_chk("t4_zero", 1, 0, 0);
      do_reset();
      frm = '{8'h00, 8'h00, 8'h5A};
      run(0, 3);
      end_chk("t4_zero_bad", 0, 1, 0);
      do_reset();
      frm = '{8'h02, 8'h58};
      run(0, 2);
      chk("t5_err_now", err, 1);
      chk("t5_ready_now", bus.rx_ready, 0);
      end_chk("t5_over", 0, 1, 0);
      do_reset();
      frm = '{8'h02, 8'h00};
      for (int i = 0; i < 2048; i++) frm.push_back(8'h00);
      frm.push_back(8'h00);
      run(0, frm.size());
      end_chk("t6_full", 1, 0, 512);
      chk("t6_last_addr", last_addr, 511);
      // reset lands on a live transfer in the middle of the second word
      do_reset();
      mk3(1'b0);
      run(0, 8);
      @(negedge clk);
      bus.rx_data = frm[8];
      bus.rx_valid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("t7_rdy_in_rst", bus.rx_ready, 0);
      rst = 1'b0;
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t7_pending", q.size(), 0);
      chk("t7_words", words, 0);
      chk("t7_core_rst", core_rst, 1);
      chk("t7_addr", addr, 0);
      chk("t7_ready", bus.rx_ready, 1);
      mk3(1'b0);
      run(2, frm.size());
      end_chk("t7_reload", 1, 0, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Hardware program loader that sits upstream of the MIPS_core instruction memory and replaces hierarchical preloading. It receives a framed byte stream (header, instruction words, checksum) over a valid/ready interface and packs bytes into 32-bit words. It writes those words into consecutive instruction-memory locations and holds the core in reset until a verified load completes.

Parameters:
IMEM_DEPTH, 512, number of 32-bit instruction-memory words.
ADDR_W, 9, word-address width, equal to $clog2(IMEM_DEPTH).
LOAD_BASE, 0, first word address written.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
rx_data_i  in  8  incoming byte.
rx_valid_i  in  1  byte valid.
rx_ready_o  out  1  loader can accept a byte.
imem_we_o  out  1  instruction-memory write strobe, one-cycle pulse.
imem_addr_o  out  ADDR_W  word address for the write.
imem_wdata_o  out  32  word to write.
core_rst_o  out  1  reset to MIPS_core; high until the load is done.
load_done_o  out  1  load verified; sticky.
load_err_o  out  1  load failed; sticky.
words_loaded_o  out  ADDR_W+1  count of words written so far.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=HDR_HI, imem_we_o=0, imem_addr_o=LOAD_BASE, imem_wdata_o=0, core_rst_o=1, load_done_o=0, load_err_o=0, words_loaded_o=0, checksum=0, byte index=0.
- Handshake: a byte transfers on a clk edge where rx_valid_i & rx_ready_o.
  - rx_ready_o = (state in {HDR_HI, HDR_LO, LOAD, CSUM}) & ~rst.
  - rx_ready_o has no dependency on rx_valid_i.
  - Gaps in rx_valid_i are legal and must not affect the result.
- Frame format: word count N as 16-bit big-endian (HDR_HI, then HDR_LO), then N words of 4 bytes each (MSB first), then 1 checksum byte. The checksum is the XOR of all data bytes; header bytes are excluded.
- State machine:
  - HDR_HI -> HDR_LO on transfer.
  - HDR_LO on transfer:
    - N==0 -> CSUM (expected checksum 0x00).
    - N > IMEM_DEPTH-LOAD_BASE -> ERR.
    - otherwise -> LOAD.
  - LOAD: each transfer shifts the byte into the word register and XORs it into the checksum.
    - On the 4th byte, the next cycle has imem_we_o=1, imem_wdata_o=assembled word, imem_addr_o=LOAD_BASE+words_loaded_o.
    - words_loaded_o increments in that same cycle.
    - Write latency is exactly 1 cycle after the 4th byte is accepted.
    - After word N is accepted -> CSUM.
    - rx_ready_o stays high during the write cycle, so back-to-back bytes must be absorbed without loss.
  - CSUM: on transfer, byte==checksum -> DONE, else -> ERR.
  - DONE: core_rst_o=0 and load_done_o=1, both registered on the cycle after the CSUM transfer. rx_ready_o=0. Further stimulus is ignored until rst.
  - ERR: core_rst_o=1, load_err_o=1, rx_ready_o=0; sticky until rst.
- Boundaries:
  - N==IMEM_DEPTH with LOAD_BASE=0 is legal; the last write is to address IMEM_DEPTH-1, with no wrap.
  - imem_addr_o holds its last value when imem_we_o=0.
  - rst in any state returns to the reset values. Memory contents already written are not cleared. A partially assembled word is discarded and is never written.
  - rst coincident with a transfer: reset wins and the byte is dropped.

Decomposition:
- mips_pkg additions:
  - typedef enum loader_state_e {LDR_HDR_HI, LDR_HDR_LO, LDR_LOAD, LDR_CSUM, LDR_DONE, LDR_ERR}.
  - localparam LDR_BYTES_PER_WORD=4.
  - localparam LDR_HDR_BYTES=2.
- Sub-module imem_word_assembler: shift register, 2-bit byte index, running XOR checksum, word_valid pulse output; has clear and enable inputs. The top level holds the FSM, address/count registers and output regs.
- MIPS_core integration: the core's rst is driven by core_rst_o. The imem write port is added to the InstructionMemory module.

Test Plan:
- 3-word load, contiguous valid: frame 00 03, 20 01 00 01, 20 0f 00 0f, 08 10 00 09, checksum 11 -> writes {0:20010001, 1:200f000f, 2:08100009}, each 1 cycle after its 4th byte. load_done_o=1, core_rst_o falls 1 cycle after the checksum, words_loaded_o=3.
- Same frame with rx_valid_i toggled randomly (gaps of 0-5 cycles) -> identical writes and final state; no duplicate or missing imem_we_o pulses.
- Bad checksum: same frame with checksum 12 -> all 3 writes occur, then load_err_o=1, core_rst_o stays 1, rx_ready_o=0, load_done_o=0.
- Zero-length: 00 00 then 00 -> no imem_we_o, load_done_o=1. Variant 00 00 then 5A -> load_err_o=1.
- Overflow: 02 58 (N=600 > 512) -> ERR the cycle after HDR_LO, no writes, rx_ready_o=0. Boundary: N=512 of 0x00000000 with checksum 00 -> last write to addr 511, load_done_o=1.
- rst mid-load after 6 data bytes (1 word written) -> state HDR_HI, words_loaded_o=0, core_rst_o=1, no write of the partial word. A subsequent full 3-word frame loads correctly from addr 0.
